// File: rtl/pipe_pal_arb.sv
// Round-robin arbiter sharing one fixed-latency pipe between N requesters,
// with bounded grant locking and a tag shift register that routes results home.
module pipe_pal_arb #(
  parameter int unsigned N        = 4,
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned W_ADDR   = 16,
  parameter int unsigned LAT      = 3,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                  i_clk,
  input  logic                  resetn,
  input  logic [N-1:0]          i_req_valid,
  input  logic [N-1:0]          i_req_lock,
  input  logic [N*W_DATA-1:0]   i_req_data,
  input  logic [N*W_ADDR-1:0]   i_req_addr,
  output logic [N-1:0]          o_req_ready,
  output logic                  o_pipe_valid,
  output logic [W_DATA-1:0]     o_pipe_data,
  output logic [W_ADDR-1:0]     o_pipe_addr,
  input  logic                  i_pipe_rvalid,
  input  logic [W_DATA-1:0]     i_pipe_rdata,
  output logic [N-1:0]          o_resp_valid,
  output logic [W_DATA-1:0]     o_resp_data,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  logic [IW-1:0] ptr_q, owner_q, issue_id_q, gnt_id;
  logic          owner_vld_q, armed_q;
  logic [CW-1:0] cnt_q, cnt_eff;
  logic [N-1:0]  gnt;
  logic          accept, lock_active, lock_ok;
  logic [LAT-1:0] tag_vld_q;
  logic [IW-1:0]  tag_id_q [LAT];
  logic           tail_vld;
  logic [IW-1:0]  tail_id;

  // A lock only holds while its owner keeps valid asserted.
  assign lock_active = owner_vld_q & i_req_valid[owner_q];
  assign cnt_eff     = lock_active ? cnt_q : '0;

  always_comb begin : p_grant
    int unsigned idx;
    idx    = 0;
    gnt    = '0;
    gnt_id = '0;
    if (lock_active) begin
      gnt[owner_q] = 1'b1;
      gnt_id       = owner_q;
    end else begin
      // Walk backwards so the nearest valid requester at/after ptr wins.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % N;
        if (i_req_valid[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_id   = IW'(idx);
        end
      end
    end
  end

  assign accept      = |gnt;
  assign lock_ok     = i_req_lock[gnt_id] && ((int'(cnt_eff) + 1) < int'(MAX_LOCK));
  assign o_req_ready = gnt;

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      owner_vld_q  <= 1'b0;
      cnt_q        <= '0;
      o_pipe_valid <= 1'b0;
      o_pipe_data  <= '0;
      o_pipe_addr  <= '0;
      issue_id_q   <= '0;
      tag_vld_q    <= '0;
      for (int k = 0; k < int'(LAT); k++) tag_id_q[k] <= '0;
      armed_q      <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      if (owner_vld_q && !lock_active) begin
        owner_vld_q <= 1'b0;
        cnt_q       <= '0;
      end
      if (accept) begin
        if (lock_ok) begin
          owner_vld_q <= 1'b1;
          owner_q     <= gnt_id;
          cnt_q       <= cnt_eff + CW'(1);
        end else begin
          owner_vld_q <= 1'b0;
          cnt_q       <= '0;
          ptr_q       <= IW'((int'(gnt_id) + 1) % N);
        end
        o_pipe_data <= i_req_data[int'(gnt_id)*W_DATA +: W_DATA];
        o_pipe_addr <= i_req_addr[int'(gnt_id)*W_ADDR +: W_ADDR];
        issue_id_q  <= gnt_id;
      end
      o_pipe_valid <= accept;
      tag_vld_q[0] <= o_pipe_valid;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < int'(LAT); k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      // Stray results from before a reset are ignored until something is issued again.
      armed_q <= armed_q | o_pipe_valid;
      o_err   <= o_err | (armed_q & (i_pipe_rvalid != tail_vld));
    end
  end

  assign tail_vld = tag_vld_q[LAT-1];
  assign tail_id  = tag_id_q[LAT-1];

  always_comb begin
    o_resp_valid = '0;
    if (i_pipe_rvalid && tail_vld) o_resp_valid[tail_id] = 1'b1;
  end

  assign o_resp_data = i_pipe_rdata;
  assign o_busy      = o_pipe_valid | (|tag_vld_q);

endmodule

// File: tb/tb_pipe_pal_arb.sv
// Scoreboard bench for pipe_pal_arb: an echo pipe model (data+1, LAT cycles)
// with expected responses queued at accept time and popped on o_resp_valid.
module tb_pipe_pal_arb;
  localparam int N = 4, W_DATA = 32, W_ADDR = 16, LAT = 3, MAX_LOCK = 4;

  logic i_clk = 1'b0;
  logic resetn;
  logic [N-1:0] i_req_valid, i_req_lock, o_req_ready, o_resp_valid;
  logic [N*W_DATA-1:0] i_req_data;
  logic [N*W_ADDR-1:0] i_req_addr;
  logic o_pipe_valid, i_pipe_rvalid, o_busy, o_err;
  logic [W_DATA-1:0] o_pipe_data, i_pipe_rdata, o_resp_data;
  logic [W_ADDR-1:0] o_pipe_addr;

  pipe_pal_arb #(.N(N), .W_DATA(W_DATA), .W_ADDR(W_ADDR), .LAT(LAT), .MAX_LOCK(MAX_LOCK)) dut (
    .i_clk(i_clk), .resetn(resetn), .i_req_valid(i_req_valid), .i_req_lock(i_req_lock),
    .i_req_data(i_req_data), .i_req_addr(i_req_addr), .o_req_ready(o_req_ready),
    .o_pipe_valid(o_pipe_valid), .o_pipe_data(o_pipe_data), .o_pipe_addr(o_pipe_addr),
    .i_pipe_rvalid(i_pipe_rvalid), .i_pipe_rdata(i_pipe_rdata), .o_resp_valid(o_resp_valid),
    .o_resp_data(o_resp_data), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Pipe model: echoes data+1 exactly LAT cycles after o_pipe_valid; not reset.
  logic [LAT-1:0]    mv = '0;
  logic [W_DATA-1:0] md [LAT];
  logic              inject = 1'b0;
  always @(posedge i_clk) begin
    mv[0] <= o_pipe_valid;
    md[0] <= o_pipe_data + 32'd1;
    for (int k = 1; k < LAT; k++) begin
      mv[k] <= mv[k-1];
      md[k] <= md[k-1];
    end
  end
  assign i_pipe_rvalid = mv[LAT-1] | inject;
  assign i_pipe_rdata  = md[LAT-1];

  typedef struct {int id; logic [W_DATA-1:0] data;} exp_t;
  exp_t sb[$];
  int   glog[$];
  int   checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop/compare responses, push expectations on every accept.
  always @(negedge i_clk) begin
    if (resetn) begin
      if (o_resp_valid != '0) begin
        if (sb.size() == 0) check_eq("resp_unexpected", 64'(o_resp_valid), 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("resp_id", 64'(o_resp_valid), 64'(4'b0001 << e.id));
          check_eq("resp_data", 64'(o_resp_data), 64'(e.data));
        end
      end
      if ($countones(o_req_ready) > 1) check_eq("ready_onehot", 64'(o_req_ready), 64'd0);
      for (int i = 0; i < N; i++) begin
        if (o_req_ready[i] && i_req_valid[i]) begin
          exp_t e;
          e.id   = i;
          e.data = i_req_data[i*W_DATA +: W_DATA] + 32'd1;
          sb.push_back(e);
          glog.push_back(i);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input int n);
    i_req_valid = v;
    i_req_lock  = l;
    repeat (n) cyc();
  endtask

  task automatic drain();
    int budget = 30;
    while (sb.size() != 0 && budget > 0) begin
      cyc();
      budget--;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [63:0] log_word();
    logic [63:0] w = '0;
    foreach (glog[i]) w = (w << 4) | 64'(glog[i]);
    return w;
  endfunction

  initial begin
    resetn      = 1'b0;
    i_req_valid = '0;
    i_req_lock  = '0;
    for (int i = 0; i < N; i++) begin
      i_req_data[i*W_DATA +: W_DATA] = 32'h1000_0000 + 32'(i);
      i_req_addr[i*W_ADDR +: W_ADDR] = 16'h0100 + 16'(i);
    end
    repeat (2) cyc();
    check_eq("rst_pipe_valid", 64'(o_pipe_valid), 64'd0);
    check_eq("rst_pipe_data", 64'(o_pipe_data), 64'd0);
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_err", 64'(o_err), 64'd0);
    check_eq("rst_resp", 64'(o_resp_valid), 64'd0);
    resetn = 1'b1;
    cyc();
    check_eq("idle_ready", 64'(o_req_ready), 64'd0);

    // Plain round robin
    glog.delete();
    i_req_valid = 4'hF;
    cyc();
    check_eq("rr_pipe_valid", 64'(o_pipe_valid), 64'd1);
    check_eq("rr_pipe_data", 64'(o_pipe_data), 64'h1000_0000);
    check_eq("rr_pipe_addr", 64'(o_pipe_addr), 64'h0100);
    repeat (4) cyc();
    drive('0, '0, 1);
    check_eq("rr_order", log_word(), 64'h01230);
    drain();
    check_eq("rr_idle_busy", 64'(o_busy), 64'd0);

    // Single request, exact latency
    i_req_data[2*W_DATA +: W_DATA] = 32'hA5A5_0001;
    i_req_addr[2*W_ADDR +: W_ADDR] = 16'h0010;
    drive(4'b0100, '0, 1);
    i_req_valid = '0;
    check_eq("one_pipe_data", 64'(o_pipe_data), 64'hA5A5_0001);
    check_eq("one_pipe_addr", 64'(o_pipe_addr), 64'h0010);
    cyc();
    check_eq("one_pipe_idle", 64'(o_pipe_valid), 64'd0);
    cyc();
    check_eq("one_resp_early", 64'(o_resp_valid), 64'd0);
    check_eq("one_busy", 64'(o_busy), 64'd1);
    cyc();
    check_eq("one_resp_valid", 64'(o_resp_valid), 64'b0100);
    check_eq("one_resp_data", 64'(o_resp_data), 64'hA5A5_0002);
    drain();

    // Lock burst capped at MAX_LOCK
    drive(4'b0001, '0, 1);
    glog.delete();
    drive(4'b1010, 4'b0010, 6);
    drive('0, '0, 1);
    check_eq("lock_order", log_word(), 64'h111131);
    drain();

    // Lock owner drops valid: lock and its count are released
    drive(4'b0001, '0, 1);
    glog.delete();
    drive(4'b0010, 4'b0010, 2);
    drive(4'b1001, 4'b1000, 5);
    drive('0, '0, 1);
    check_eq("unlock_order", log_word(), 64'h1133330);
    drain();

    // Spurious pipe result
    check_eq("err_before", 64'(o_err), 64'd0);
    inject = 1'b1;
    #3;
    check_eq("spur_no_resp", 64'(o_resp_valid), 64'd0);
    cyc();
    inject = 1'b0;
    check_eq("spur_err_set", 64'(o_err), 64'd1);
    repeat (3) cyc();
    check_eq("spur_err_sticky", 64'(o_err), 64'd1);

    // Reset with three operations in flight
    drive(4'b0111, '0, 3);
    i_req_valid = '0;
    check_eq("inflight_busy", 64'(o_busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    sb.delete();
    check_eq("async_pipe_valid", 64'(o_pipe_valid), 64'd0);
    check_eq("async_busy", 64'(o_busy), 64'd0);
    check_eq("async_err", 64'(o_err), 64'd0);
    check_eq("async_resp", 64'(o_resp_valid), 64'd0);
    check_eq("async_addr", 64'(o_pipe_addr), 64'd0);
    cyc();
    resetn = 1'b1;
    repeat (LAT + 2) cyc();
    check_eq("late_err", 64'(o_err), 64'd0);
    drive(4'b0001, '0, 1);
    drive('0, '0, 1);
    drain();
    cyc();
    check_eq("post_rst_err", 64'(o_err), 64'd0);
    check_eq("post_rst_busy", 64'(o_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
